tenkey_driver: RTL
==================

// Module: tenkey_driver
// PURPOSE
//   Decoder/driver for the tenkey interface. Accepts 4-bit key codes over a valid/ready handshake.
//   Replays each code as a timed one-hot tenkey "press" followed by a release gap.
//   Also drives the lock's close input. Used by host/test logic to operate the electronic lock
//   as a person at the keypad would; it is the inverse of the lock's one-hot->code encoder.
// PARAMETERS
//   PRESS_CYCLES  4   cycles a key (or close) is held asserted; legal 1..2**CNT_W
//   GAP_CYCLES    2   cycles all outputs are released after a press; legal 1..2**CNT_W
//   CNT_W         8   width of the internal hold/gap down-counter
// PORTS
//   clk          in   1   single clock, all logic on posedge
//   rst          in   1   synchronous, active-high reset
//   digit_valid  in   1   code on digit is offered
//   digit        in   4   0x0-0x9 = key 0-9, 0xC = close, all others illegal
//   digit_ready  out  1   block can accept a code this cycle
//   tenkey       out  10  one-hot key press: bit n = key n; all-zero = no key
//   close        out  1   close request, held like a key press
//   busy         out  1   press or gap sequence in progress
//   err          out  1   one-cycle pulse: illegal code was accepted and dropped
// BEHAVIOUR
//   Reset values: tenkey=0, close=0, busy=0, err=0, state=IDLE, counter=0.
//   digit_ready is 0 while rst=1.
//   Outputs tenkey/close/err are registered. busy = (state!=IDLE).
//   digit_ready = (state==IDLE) & ~rst.
//   Transfer occurs on a posedge with digit_valid & digit_ready. digit is sampled only then.
//   digit_valid while not ready is ignored; the source holds it, and nothing is queued.
//   FSM IDLE -> PRESS -> GAP -> IDLE:
//   - IDLE, legal key n: tenkey <= 1<<n, cnt <= PRESS_CYCLES-1, -> PRESS.
//   - IDLE, code 0xC: close <= 1, tenkey stays 0, cnt <= PRESS_CYCLES-1, -> PRESS.
//   - IDLE, illegal (0xA,0xB,0xD-0xF): err <= 1 for exactly one cycle, stay IDLE, ready stays 1.
//   - PRESS: cnt==0 -> tenkey <= 0, close <= 0, cnt <= GAP_CYCLES-1, -> GAP; else cnt--.
//   - GAP: cnt==0 -> IDLE; else cnt--.
//   Timing from the accept edge E:
//   - tenkey/close asserted from cycle E+1 for exactly PRESS_CYCLES cycles.
//   - Then zero for exactly GAP_CYCLES cycles.
//   - digit_ready=1 again in cycle E+PRESS_CYCLES+GAP_CYCLES+1.
//   - Minimum code spacing is PRESS_CYCLES+GAP_CYCLES+1 cycles.
//   Invariants: tenkey is always 0 or exactly one-hot.
//   tenkey and close are never asserted together. err is never asserted with busy rising.
//   Counter reaches 0 and reloads; it never wraps below 0.
//   Reset mid-PRESS/GAP: on the reset edge, all outputs clear and the in-flight code is discarded.
//   There is no release gap after a reset.
// STRUCTURE
//   Shared header tenkey_defs.vh:
//   - state encodings ST_IDLE/ST_PRESS/ST_GAP (2-bit)
//   - CODE_CLOSE=4'hC
//   - TENKEY_W=10
//   One sub-module tenkey_dec (combinational):
//   - input code[3:0]; outputs onehot[9:0], is_key, is_close.
//   - Mirrors the lock's encoder table exactly.
//   tenkey_driver holds the FSM, counter, handshake and output registers.
// TESTING
//   1. Reset, offer digit=7 -> tenkey=10'b0010000000 cycles 1-4, 0 cycles 5-6, digit_ready=1 cycle 7, busy=1 cycles 1-6.
//   2. digit=0xC -> close=1 for 4 cycles, tenkey=0 throughout, then 2-cycle gap.
//   3. digit=0xA -> err=1 for one cycle, tenkey=0, busy=0, digit_ready stays 1.
//   4. digit_valid held with 3 then 9 -> second accept exactly 7 cycles after first, tenkey bit 9 follows bit 3 after gap.
//   5. rst=1 during PRESS of digit 5 -> next edge tenkey=0, busy=0. After rst=0, digit_ready=1 and the next code is accepted.
//   6. Sweep digits 0-9 back-to-back -> each tenkey is one-hot and matches its digit. Chain into the lock with SECRET=7: lock=0 after 7, close code relocks.

Source files
------------

// File: rtl/tenkey_driver_pkg.sv
// Shared definitions for the tenkey driver: FSM state encoding, code values, bus widths.
package tenkey_driver_pkg;

    localparam int unsigned TENKEY_W = 10;
    localparam int unsigned CODE_W   = 4;

    localparam logic [CODE_W-1:0] CODE_CLOSE = 4'hC;
    localparam logic [CODE_W-1:0] CODE_MAX_KEY = 4'h9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRESS = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/tenkey_driver_dec.sv
// Code -> one-hot tenkey decoder; inverse of the lock's one-hot -> code encoder.
module tenkey_driver_dec
    import tenkey_driver_pkg::*;
(
    input  logic [CODE_W-1:0]   code,
    output logic [TENKEY_W-1:0] onehot,
    output logic                is_key,
    output logic                is_close
);

    // Keys 0-9 map to bit n; close and illegal codes give no key bit.
    always_comb begin
        onehot   = '0;
        is_key   = 1'b0;
        is_close = 1'b0;
        if (code <= CODE_MAX_KEY) begin
            onehot = TENKEY_W'(1) << code;
            is_key = 1'b1;
        end else if (code == CODE_CLOSE) begin
            is_close = 1'b1;
        end
    end

endmodule

// File: rtl/tenkey_driver.sv
// Replays accepted key codes as timed one-hot tenkey presses (or a close press)
// followed by a release gap, with a valid/ready intake.
module tenkey_driver
    import tenkey_driver_pkg::*;
#(
    parameter int unsigned PRESS_CYCLES = 4,
    parameter int unsigned GAP_CYCLES   = 2,
    parameter int unsigned CNT_W        = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                digit_valid,
    input  logic [CODE_W-1:0]   digit,
    output logic                digit_ready,
    output logic [TENKEY_W-1:0] tenkey,
    output logic                close,
    output logic                busy,
    output logic                err
);

    localparam logic [CNT_W-1:0] PRESS_LOAD = CNT_W'(PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);

    state_t              state_q;
    state_t              state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic [TENKEY_W-1:0] tenkey_d;
    logic                close_d;
    logic                err_d;

    logic [TENKEY_W-1:0] dec_onehot;
    logic                dec_is_key;
    logic                dec_is_close;
    logic                accept;

    tenkey_driver_dec u_dec (
        .code     (digit),
        .onehot   (dec_onehot),
        .is_key   (dec_is_key),
        .is_close (dec_is_close)
    );

    assign digit_ready = (state_q == ST_IDLE) & ~rst;
    assign busy        = (state_q != ST_IDLE);
    assign accept      = digit_valid & digit_ready;

    // State register; reset discards any in-flight press without a gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: illegal codes are dropped and leave the FSM in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && (dec_is_key || dec_is_close)) begin
                    state_d = ST_PRESS;
                end
            end
            ST_PRESS: begin
                if (cnt_q == '0) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values for the counter and the registered outputs.
    always_comb begin
        cnt_d    = cnt_q;
        tenkey_d = tenkey;
        close_d  = close;
        err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (dec_is_key) begin
                        tenkey_d = dec_onehot;
                        cnt_d    = PRESS_LOAD;
                    end else if (dec_is_close) begin
                        close_d = 1'b1;
                        cnt_d   = PRESS_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_PRESS: begin
                if (cnt_q == '0) begin
                    tenkey_d = '0;
                    close_d  = 1'b0;
                    cnt_d    = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                cnt_d    = '0;
                tenkey_d = '0;
                close_d  = 1'b0;
            end
        endcase
    end

    // Counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tenkey <= '0;
            close  <= 1'b0;
            err    <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tenkey <= tenkey_d;
            close  <= close_d;
            err    <= err_d;
        end
    end

endmodule
